// File: rtl/pipelined_decoder_pkg.sv
// ============================================================================
// pipelined_decoder_pkg : opcode/funct encodings and control-bundle type
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipelined_decoder_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [2:0] ALU_OP_ADD = 3'd0;
  localparam logic [2:0] ALU_OP_SUB = 3'd1;
  localparam logic [2:0] ALU_OP_AND = 3'd2;
  localparam logic [2:0] ALU_OP_OR  = 3'd3;
  localparam logic [2:0] ALU_OP_SLT = 3'd4;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src;
    logic       reg_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic       branch;
    logic       jump;
    logic       jump_reg;
    logic       link;
    logic       illegal;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/pipelined_decoder_decode_logic.sv
// ============================================================================
// decode_logic : combinational instruction -> control bundle table
// Revision: 1.0
// ============================================================================
`default_nettype none

module decode_logic
  import pipelined_decoder_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LINK_REG = 31
) (
  input  logic [31:0]       instr,
  output logic [REG_AW-1:0] rs_addr,
  output logic [REG_AW-1:0] rt_addr,
  output logic [REG_AW-1:0] wr_addr,
  output logic [25:0]       imm26,
  output ctrl_t             ctrl,
  output logic              uses_rt
);

  localparam logic [REG_AW-1:0] c_link = REG_AW'(LINK_REG);

  logic [REG_AW-1:0] w_rd;
  logic [REG_AW-1:0] w_wr;

  assign rs_addr = REG_AW'(instr[25:21]);
  assign rt_addr = REG_AW'(instr[20:16]);
  assign w_rd    = REG_AW'(instr[15:11]);
  assign imm26   = instr[25:0];
  assign wr_addr = w_wr;

  always_comb begin
    ctrl    = '0;
    w_wr    = '0;
    uses_rt = 1'b0;
    case (instr[31:26])
      OP_RTYPE: begin
        uses_rt = 1'b1;
        case (instr[5:0])
          FN_ADD, FN_ADDU: begin ctrl.alu_op = ALU_OP_ADD; ctrl.reg_wr = 1'b1; w_wr = w_rd; end
          FN_SUB:          begin ctrl.alu_op = ALU_OP_SUB; ctrl.reg_wr = 1'b1; w_wr = w_rd; end
          FN_AND:          begin ctrl.alu_op = ALU_OP_AND; ctrl.reg_wr = 1'b1; w_wr = w_rd; end
          FN_OR:           begin ctrl.alu_op = ALU_OP_OR;  ctrl.reg_wr = 1'b1; w_wr = w_rd; end
          FN_SLT:          begin ctrl.alu_op = ALU_OP_SLT; ctrl.reg_wr = 1'b1; w_wr = w_rd; end
          FN_JR:           ctrl.jump_reg = 1'b1;
          default:         ctrl.illegal  = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl.alu_src = 1'b1;
        ctrl.reg_wr  = 1'b1;
        w_wr         = rt_addr;
      end
      OP_LW: begin
        ctrl.alu_src = 1'b1;
        ctrl.mem_rd  = 1'b1;
        ctrl.reg_wr  = 1'b1;
        w_wr         = rt_addr;
      end
      OP_SW: begin
        uses_rt      = 1'b1;
        ctrl.alu_src = 1'b1;
        ctrl.mem_wr  = 1'b1;
      end
      OP_BEQ: begin
        uses_rt      = 1'b1;
        ctrl.branch  = 1'b1;
        ctrl.alu_op  = ALU_OP_SUB;
      end
      OP_J: ctrl.jump = 1'b1;
      OP_JAL: begin
        ctrl.jump   = 1'b1;
        ctrl.link   = 1'b1;
        ctrl.reg_wr = 1'b1;
        w_wr        = c_link;
      end
      default: ctrl.illegal = 1'b1;
    endcase
    // $0 is hardwired, so a write to it is never a real write
    if (w_wr == '0) ctrl.reg_wr = 1'b0;
  end

endmodule

`default_nettype wire

// File: rtl/pipelined_decoder.sv
// ============================================================================
// pipelined_decoder : registered decode stage with load-use bubble and flush
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipelined_decoder
  import pipelined_decoder_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int LINK_REG    = 31,
  parameter int HAZARD_EN   = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            instr,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [REG_AW-1:0]      rs_addr,
  output logic [REG_AW-1:0]      rt_addr,
  output logic [REG_AW-1:0]      wr_addr,
  output logic [15:0]            imm16,
  output logic [25:0]            imm26,
  output logic [2:0]             alu_op,
  output logic                   alu_src,
  output logic                   reg_wr,
  output logic                   mem_rd,
  output logic                   mem_wr,
  output logic                   branch,
  output logic                   jump,
  output logic                   jump_reg,
  output logic                   link,
  output logic                   illegal,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic [REG_AW-1:0]      w_rs, w_rt, w_wr;
  logic [25:0]            w_imm26;
  ctrl_t                  w_ctrl;
  logic                   w_uses_rt;
  logic                   w_adv, w_hazard, w_accept;

  logic                   r_out_valid;
  ctrl_t                  r_ctrl;
  logic [REG_AW-1:0]      r_rs, r_rt, r_wr;
  logic [25:0]            r_imm26;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  decode_logic #(
    .REG_AW   (REG_AW),
    .LINK_REG (LINK_REG)
  ) u_decode (
    .instr    (instr),
    .rs_addr  (w_rs),
    .rt_addr  (w_rt),
    .wr_addr  (w_wr),
    .imm26    (w_imm26),
    .ctrl     (w_ctrl),
    .uses_rt  (w_uses_rt)
  );

  assign w_adv    = !r_out_valid || out_ready;
  // Load result not available until after execute: the consumer must wait a cycle
  assign w_hazard = (HAZARD_EN != 0) && r_out_valid && r_ctrl.mem_rd && (r_wr != '0) && in_valid &&
                    ((r_wr == w_rs) || (w_uses_rt && (r_wr == w_rt)));
  assign w_accept = in_valid && in_ready;
  assign in_ready = w_adv && !w_hazard && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_ctrl      <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_wr        <= '0;
      r_imm26     <= '0;
      r_stall_cnt <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_ctrl      <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_wr        <= '0;
      r_imm26     <= '0;
    end else if (w_adv) begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_ctrl      <= w_ctrl;
        r_rs        <= w_rs;
        r_rt        <= w_rt;
        r_wr        <= w_wr;
        r_imm26     <= w_imm26;
      end else begin
        r_out_valid <= 1'b0;
        r_ctrl      <= '0;
        r_rs        <= '0;
        r_rt        <= '0;
        r_wr        <= '0;
        r_imm26     <= '0;
      end
      if (w_hazard && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign rs_addr   = r_rs;
  assign rt_addr   = r_rt;
  assign wr_addr   = r_wr;
  assign imm26     = r_imm26;
  assign imm16     = r_imm26[15:0];
  assign alu_op    = r_ctrl.alu_op;
  assign alu_src   = r_ctrl.alu_src;
  assign reg_wr    = r_ctrl.reg_wr;
  assign mem_rd    = r_ctrl.mem_rd;
  assign mem_wr    = r_ctrl.mem_wr;
  assign branch    = r_ctrl.branch;
  assign jump      = r_ctrl.jump;
  assign jump_reg  = r_ctrl.jump_reg;
  assign link      = r_ctrl.link;
  assign illegal   = r_ctrl.illegal;
  assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_decoder.sv
// ============================================================================
// tb_pipelined_decoder : decode table vectors, hazard/flush/saturation sequences, random run
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipelined_decoder;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]   instr;
  logic [4:0]    rs_addr, rt_addr, wr_addr;
  logic [15:0]   imm16;
  logic [25:0]   imm26;
  logic [2:0]    alu_op;
  logic          alu_src, reg_wr, mem_rd, mem_wr, branch, jump, jump_reg, link, illegal;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipelined_decoder #(
    .REG_AW(5), .LINK_REG(31), .HAZARD_EN(1), .STALL_CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .wr_addr(wr_addr), .imm16(imm16), .imm26(imm26),
    .alu_op(alu_op), .alu_src(alu_src), .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .branch(branch), .jump(jump), .jump_reg(jump_reg), .link(link), .illegal(illegal),
    .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic [4:0]  rs, rt, wr;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [2:0]  alu_op;
    logic        alu_src, reg_wr, mem_rd, mem_wr, branch, jump, jump_reg, link, illegal;
  } bun_t;

  bun_t dut_b;
  assign dut_b = {rs_addr, rt_addr, wr_addr, imm16, imm26, alu_op, alu_src, reg_wr,
                  mem_rd, mem_wr, branch, jump, jump_reg, link, illegal};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, got, exp);
    end
  endtask

  // Reference decode straight from the instruction-set table
  function automatic bun_t ref_decode(input logic [31:0] w);
    bun_t b;
    logic [5:0] op, fn;
    b = '0;
    op = w[31:26];
    fn = w[5:0];
    b.rs = w[25:21]; b.rt = w[20:16]; b.imm16 = w[15:0]; b.imm26 = w[25:0];
    if (op == 6'h00) begin
      if (fn == 6'h20 || fn == 6'h21)      begin b.alu_op = 3'd0; b.reg_wr = 1'b1; b.wr = w[15:11]; end
      else if (fn == 6'h22)                begin b.alu_op = 3'd1; b.reg_wr = 1'b1; b.wr = w[15:11]; end
      else if (fn == 6'h24)                begin b.alu_op = 3'd2; b.reg_wr = 1'b1; b.wr = w[15:11]; end
      else if (fn == 6'h25)                begin b.alu_op = 3'd3; b.reg_wr = 1'b1; b.wr = w[15:11]; end
      else if (fn == 6'h2A)                begin b.alu_op = 3'd4; b.reg_wr = 1'b1; b.wr = w[15:11]; end
      else if (fn == 6'h08)                b.jump_reg = 1'b1;
      else                                 b.illegal = 1'b1;
    end
    else if (op == 6'h08 || op == 6'h09)   begin b.alu_src = 1'b1; b.reg_wr = 1'b1; b.wr = w[20:16]; end
    else if (op == 6'h23)                  begin b.alu_src = 1'b1; b.mem_rd = 1'b1; b.reg_wr = 1'b1; b.wr = w[20:16]; end
    else if (op == 6'h2B)                  begin b.alu_src = 1'b1; b.mem_wr = 1'b1; end
    else if (op == 6'h04)                  begin b.branch = 1'b1; b.alu_op = 3'd1; end
    else if (op == 6'h02)                  b.jump = 1'b1;
    else if (op == 6'h03)                  begin b.jump = 1'b1; b.link = 1'b1; b.reg_wr = 1'b1; b.wr = 5'd31; end
    else                                   b.illegal = 1'b1;
    if (b.wr == 5'd0) b.reg_wr = 1'b0;
    return b;
  endfunction

  function automatic logic reads_rt(input logic [31:0] w);
    return (w[31:26] == 6'h00) || (w[31:26] == 6'h2B) || (w[31:26] == 6'h04);
  endfunction

  logic          m_valid;
  bun_t          m_b;
  logic [CW-1:0] m_cnt;
  logic          last_rdy;

  task automatic model_reset();
    m_valid = 1'b0; m_b = '0; m_cnt = '0;
  endtask

  // One clock: drive at negedge, check in_ready, advance model, check registered outputs
  task automatic step(input logic iv, input logic [31:0] ins, input logic fl, input logic ordy);
    logic adv, haz, rdy;
    bun_t nb;
    @(negedge clk);
    in_valid = iv; instr = ins; flush = fl; out_ready = ordy;
    #1;
    nb  = ref_decode(ins);
    adv = !m_valid || ordy;
    haz = m_valid && m_b.mem_rd && (m_b.wr != 5'd0) && iv &&
          ((m_b.wr == nb.rs) || (reads_rt(ins) && (m_b.wr == nb.rt)));
    rdy = adv && !haz && !fl;
    last_rdy = in_ready;
    chk("in_ready", in_ready, rdy);
    if (fl) begin
      m_valid = 1'b0; m_b = '0;
    end else if (adv) begin
      if (iv && rdy) begin m_valid = 1'b1; m_b = nb; end
      else           begin m_valid = 1'b0; m_b = '0; end
      if (haz && m_cnt != '1) m_cnt = m_cnt + 1'b1;
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("bundle", dut_b, m_b);
    chk("stall_cnt", stall_cnt, m_cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; instr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset bundle", dut_b, '0);
    chk("reset stall_cnt", stall_cnt, '0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [4:0] a, b, c;
    logic [5:0] fns [6];
    fns = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h2A};
    a = 5'($urandom_range(0, 3)); b = 5'($urandom_range(0, 3)); c = 5'($urandom_range(0, 3));
    w = $urandom;
    case ($urandom_range(0, 11))
      0:  w = {6'h00, a, b, c, 5'd0, fns[$urandom_range(0, 5)]};
      1:  w = {6'h00, a, 15'd0, 6'h08};
      2:  w = {6'h00, a, b, c, 5'd0, 6'h3F};
      3:  w = {6'h08, a, b, w[15:0]};
      4:  w = {6'h09, a, b, w[15:0]};
      5,
      6:  w = {6'h23, a, b, w[15:0]};
      7:  w = {6'h2B, a, b, w[15:0]};
      8:  w = {6'h04, a, b, w[15:0]};
      9:  w = {6'h02, w[25:0]};
      10: w = {6'h03, w[25:0]};
      default: ;
    endcase
    return w;
  endfunction

  typedef struct {
    logic [31:0] ins;
    logic [4:0]  wr;
    logic [11:0] fl;  // {alu_op, alu_src, reg_wr, mem_rd, mem_wr, branch, jump, jump_reg, link, illegal}
  } vec_t;

  localparam logic [31:0] LW9  = 32'h8D09_0000;  // lw  $9,0($8)
  localparam logic [31:0] ADD  = 32'h0128_5020;  // add $10,$9,$8
  localparam logic [31:0] ADDI = 32'h2008_0005;  // addi $8,$0,5

  initial begin
    vec_t vecs[15];
    logic [31:0] ins;
    vecs = '{
      '{32'h2008_0005, 5'd8,  {3'd0, 9'b110000000}},
      '{32'h0128_5020, 5'd10, {3'd0, 9'b010000000}},
      '{32'h0022_1822, 5'd3,  {3'd1, 9'b010000000}},
      '{32'h00A6_2024, 5'd4,  {3'd2, 9'b010000000}},
      '{32'h00E7_3825, 5'd7,  {3'd3, 9'b010000000}},
      '{32'h0022_002A, 5'd0,  {3'd4, 9'b000000000}},
      '{32'h03E0_0008, 5'd0,  {3'd0, 9'b000000100}},
      '{32'h0000_003F, 5'd0,  {3'd0, 9'b000000001}},
      '{32'h8D09_0000, 5'd9,  {3'd0, 9'b111000000}},
      '{32'h0800_0100, 5'd0,  {3'd0, 9'b000001000}},
      '{32'hAD09_0004, 5'd0,  {3'd0, 9'b100100000}},
      '{32'h1022_0003, 5'd0,  {3'd1, 9'b000010000}},
      '{32'h0C00_0040, 5'd31, {3'd0, 9'b010001010}},
      '{32'hFC00_0000, 5'd0,  {3'd0, 9'b000000001}},
      '{32'h24A5_FFFF, 5'd5,  {3'd0, 9'b110000000}}
    };
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; instr = '0;
    last_rdy = 1'b0;
    model_reset();

    // Decode table
    do_reset();
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].ins, 1'b0, 1'b1);
      ins = vecs[i].ins;
      chk("vec accepted", last_rdy, 1'b1);
      chk("vec valid", out_valid, 1'b1);
      chk("vec wr_addr", wr_addr, vecs[i].wr);
      chk("vec flags", {alu_op, alu_src, reg_wr, mem_rd, mem_wr, branch, jump, jump_reg, link, illegal}, vecs[i].fl);
      chk("vec imm26", imm26, ins[25:0]);
      chk("vec imm16", imm16, ins[15:0]);
      step(1'b0, 32'h0, 1'b0, 1'b1);
    end

    // Load-use bubble
    do_reset();
    step(1'b1, LW9, 1'b0, 1'b1);
    step(1'b1, ADD, 1'b0, 1'b1);
    chk("hazard in_ready", last_rdy, 1'b0);
    chk("hazard bubble", out_valid, 1'b0);
    step(1'b1, ADD, 1'b0, 1'b1);
    chk("after bubble valid", out_valid, 1'b1);
    chk("after bubble wr", wr_addr, 5'd10);
    chk("after bubble cnt", stall_cnt, 2'd1);

    // lw to $0 never creates a hazard
    do_reset();
    step(1'b1, 32'h8D00_0000, 1'b0, 1'b1);
    chk("lw0 reg_wr", reg_wr, 1'b0);
    chk("lw0 mem_rd", mem_rd, 1'b1);
    step(1'b1, 32'h0008_5020, 1'b0, 1'b1);
    chk("lw0 no stall", last_rdy, 1'b1);
    chk("lw0 cnt", stall_cnt, 2'd0);

    // Backpressure hold then flush
    do_reset();
    step(1'b1, ADDI, 1'b0, 1'b0);
    repeat (3) begin
      step(1'b1, ADD, 1'b0, 1'b0);
      chk("hold in_ready", last_rdy, 1'b0);
      chk("hold wr", wr_addr, 5'd8);
      chk("hold imm16", imm16, 16'd5);
    end
    step(1'b1, ADD, 1'b1, 1'b0);
    chk("flush in_ready", last_rdy, 1'b0);
    chk("flush valid", out_valid, 1'b0);
    step(1'b1, ADD, 1'b0, 1'b0);
    chk("post flush accept", last_rdy, 1'b1);
    chk("post flush wr", wr_addr, 5'd10);

    // Counter saturation and async reset mid-stall
    do_reset();
    repeat (5) begin
      step(1'b1, LW9, 1'b0, 1'b1);
      step(1'b1, ADD, 1'b0, 1'b1);
      step(1'b1, ADD, 1'b0, 1'b1);
    end
    chk("saturated", stall_cnt, 2'd3);
    step(1'b1, LW9, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b1; instr = ADD; out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst valid", out_valid, 1'b0);
    chk("async rst cnt", stall_cnt, 2'd0);
    chk("async rst bundle", dut_b, '0);
    model_reset();

    // Random traffic against the reference model
    do_reset();
    for (int n = 0; n < 800; n++)
      step(($urandom_range(0, 9) < 7), rand_instr(), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 7));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipelined_decoder.md
Name: pipelined_decoder

Overview:
- Registered decode stage for the MIPS-subset core; successor to the combinational instruction decoder.
- Accepts one 32-bit instruction per cycle over a valid/ready handshake and emits a registered control bundle to execute.
- Inserts a one-cycle bubble on load-use hazards and supports flush on redirect.
- Decodes an explicit write address instead of a RegDst select, flags illegal opcodes, and keeps a saturating stall counter.

Parameters:
- REG_AW, 5, register-address width; Rs/Rt/Rd fields are taken from instruction bits and zero-extended or truncated to REG_AW.
- LINK_REG, 31, destination register for jal.
- HAZARD_EN, 1, 1 enables load-use bubble insertion; 0 never stalls on hazards.
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  decoder accepts the instruction this cycle.
- instr  in  32  instruction word.
- flush  in  1  drop the output register contents this cycle.
- out_valid  out  1  control bundle valid.
- out_ready  in  1  execute consumes the bundle.
- rs_addr, rt_addr, wr_addr  out  REG_AW each  source and destination addresses.
- imm16  out  16  instr[15:0].
- imm26  out  26  instr[25:0].
- alu_op  out  3  0=add, 1=sub, 2=and, 3=or, 4=slt.
- alu_src  out  1  1 selects immediate.
- reg_wr  out  1  register write enable.
- mem_rd  out  1  load.
- mem_wr  out  1  store.
- branch  out  1  beq.
- jump  out  1  j/jal.
- jump_reg  out  1  jr.
- link  out  1  jal (write PC+4).
- illegal  out  1  unsupported opcode/funct.
- stall_cnt  out  STALL_CNT_W  count of hazard bubbles, saturating.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, all bundle outputs 0, stall_cnt=0.
- Decode table (all fields default 0):
  - R-type (op 000000), funct 100000/100001 → add; 100010 → sub; 100100 → and; 100101 → or; 101010 → slt. All set reg_wr=1, wr_addr=rd.
  - funct 001000 (jr): jump_reg=1, reg_wr=0.
  - Any other funct: illegal=1.
  - addi/addiu (001000/001001): alu_src=1, reg_wr=1, wr_addr=rt, add.
  - lw (100011): alu_src=1, mem_rd=1, reg_wr=1, wr_addr=rt.
  - sw (101011): alu_src=1, mem_wr=1.
  - beq (000100): branch=1, alu_op=sub.
  - j (000010): jump=1.
  - jal (000011): jump=1, link=1, reg_wr=1, wr_addr=LINK_REG.
  - Any other opcode: illegal=1, all enables 0; it still passes through as a valid bundle.
  - reg_wr is forced to 0 when wr_addr==0.
- Output register advances when adv = !out_valid | out_ready.
- hazard = HAZARD_EN & out_valid & mem_rd & (wr_addr!=0) & in_valid & (wr_addr==src_rs | (uses_rt & wr_addr==src_rt)).
  - uses_rt is 1 for R-type, sw and beq.
  - src_rs/src_rt are the incoming instruction's decoded addresses.
- in_ready = adv & !hazard & !flush.
- On adv:
  - If in_valid & in_ready: load the decoded bundle, out_valid=1.
  - Else: out_valid=0 and bundle fields cleared (a bubble).
  - Latency is 1 cycle from accept to out_valid.
- Hazard while adv: a bubble is loaded and stall_cnt increments, saturating at all-ones. The next cycle the hazard is gone and the instruction is accepted.
- Hazard while !adv: hold state; in_ready=0; no count.
- flush=1: out_valid→0 and fields cleared at the next edge regardless of out_ready; in_ready=0 that cycle; stall_cnt unchanged. Flush has priority over hazard and accept.
- The bundle is stable while out_valid & !out_ready.
- Reset mid-stream discards the held bundle; stall_cnt is cleared.

Decomposition:
- Shared package holds: opcode and funct localparams (OP_RTYPE, OP_ADDI, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, FN_ADD, FN_ADDU, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_JR) and ALU_OP_* encodings.
- Sub-module decode_logic: purely combinational instr→bundle table.
- The top module owns the handshake, hazard detection, output register and counter.

Test Plan:
- Reset, then feed addi $8,$0,5 (0x20080005) with out_ready=1 → next cycle out_valid=1, alu_src=1, reg_wr=1, wr_addr=8, imm16=5, alu_op=0.
- lw $9,0($8) followed by add $10,$9,$8 back-to-back → one bubble cycle (out_valid=0, in_ready=0 during hazard), add emitted next, stall_cnt=1.
- lw $0 then add using $0 → no bubble, stall_cnt stays 0; lw bundle has reg_wr=0.
- jal 0x0000040 → jump=1, link=1, wr_addr=31, imm26=0x40; opcode 0x3F → illegal=1 with all enables 0.
- Hold out_ready=0 for 3 cycles with in_valid=1 → bundle stable, in_ready=0; then flush=1 → out_valid=0 next cycle, instruction not accepted that cycle.
- Force 2^STALL_CNT_W+2 hazards (STALL_CNT_W=2 build) → stall_cnt saturates at 3; assert rst_n low mid-stall → outputs and counter zero immediately.
